// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and load/store (port 1).
// Latency: accept edge k -> mem_valid from k+1 -> done one cycle after mem_ready (min 2 cycles).
// Backpressure: gnt is low while a transaction is outstanding; an optional BUSY timeout is enabled by ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              owner_sel,
    output logic              busy,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    // Port served most recently; a tie goes to the other one.
    logic   last_grant;

    // Reject impossible timeout settings at elaboration time.
    generate
        if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("mem_port_arbiter: TIMEOUT must be in 2..65535");
        end
    endgenerate

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    // BUSY cycles seen so far without mem_ready.
    logic [CW-1:0] to_cnt;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // Grants only in IDLE; round-robin on a tie.
    assign gnt0 = (state == IDLE) & req0 & (~req1 | last_grant);
    assign gnt1 = (state == IDLE) & req1 & (~req0 | ~last_grant);
    assign busy = (state == BUSY);

    // Arbitration FSM: latch winner's command, hold it until completion, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_sel  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            rdata      <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err0       <= 1'b0;
            err1       <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err0  <= 1'b0;
            err1  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        mem_addr   <= gnt1 ? addr1  : addr0;
                        mem_wdata  <= gnt1 ? wdata1 : wdata0;
                        mem_we     <= gnt1 ? we1    : we0;
                        owner_sel  <= gnt1;
                        last_grant <= gnt1;
                        mem_valid  <= 1'b1;
                        state      <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        // Writes return zero so rdata never shows stale bus data.
                        rdata     <= mem_we ? '0 : mem_rdata;
                        done0     <= ~owner_sel;
                        done1     <= owner_sel;
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_MAX) begin
                        rdata     <= '0;
                        done0     <= ~owner_sel;
                        done1     <= owner_sel;
                        err0      <= ~owner_sel;
                        err1      <= owner_sel;
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Round-robin arbitration with a valid/ready request handshake.
- Latches the winner's command, holds it on the memory port until mem_ready, then returns read data with a per-port done pulse.
- Drives owner_sel, the select line for the 32-bit 2:1 steering mux in the datapath.

Parameters:
- DATA_W, 32, data width of wdata/rdata.
- ADDR_W, 32, address width.
- TIMEOUT, 16, BUSY cycles without mem_ready before abort (used only with ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  request valid, per port.
- addr0, addr1  in  ADDR_W  request address.
- wdata0, wdata1  in  DATA_W  write data.
- we0, we1  in  1  1 = write, 0 = read.
- gnt0, gnt1  out  1  request accepted (ready), combinational.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  completion was a timeout abort; valid with done.
- rdata  out  DATA_W  read data, valid while the owning done is high.
- owner_sel  out  1  port of the current/last transaction (0/1).
- busy  out  1  state == BUSY.
- mem_valid  out  1  command valid to memory.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_we  out  1  latched write enable.
- mem_ready  in  1  memory completion for the current command.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; mem_valid, mem_we, busy, done0/1, err0/1, owner_sel 0; mem_addr, mem_wdata, rdata 0; last_grant 1, so port 0 wins the first tie; timeout counter 0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - gnt0 = req0 & (~req1 | last_grant == 1).
  - gnt1 = req1 & (~req0 | last_grant == 0).
  - At most one gnt is high; both gnt are 0 outside IDLE.
  - On an edge with gntN high: latch addrN/wdataN/weN into the mem_* registers, owner_sel <= N, last_grant <= N, state <= BUSY.
  - Acceptance is the handshake. A requester keeping reqN high after gntN is presenting a new request.
- BUSY:
  - mem_valid = 1; mem_addr/mem_wdata/mem_we are stable.
  - On an edge with mem_ready = 1: rdata <= mem_rdata (0 for writes), doneN <= 1 for one cycle for N = owner_sel, mem_valid <= 0, state <= IDLE.
- Latency: accept edge at cycle k; mem_valid high from k+1; mem_ready at cycle k+1+w gives done at cycle k+2+w. Minimum is 2 cycles from accept to done.
- The done cycle is an IDLE cycle, so arbitration for the next transaction happens in that same cycle (back-to-back allowed). A tie goes to the port not served last, giving strict alternation under continuous contention.
- A single requester with req held is served every 2+w cycles with no starvation or idle penalty.
- mem_ready in IDLE is ignored.
- Reset asserted mid-transaction aborts it silently: no done is generated and mem_valid drops immediately.
- rdata holds its value until the next completion.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT)) clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When the counter equals TIMEOUT-1 and mem_ready = 0: doneN and errN pulse together, rdata <= 0, state <= IDLE.
  - mem_ready in that same cycle takes precedence: normal completion, errN = 0.
- Not defined: BUSY waits indefinitely; err0/err1 are tied to 0; no counter logic.

Test Plan:
- Reset release, req0 = 1, addr0 = 0x100, we0 = 0, mem_ready high 1 cycle after mem_valid with mem_rdata = 0xDEADBEEF -> gnt0 in cycle 0, mem_addr = 0x100, done0 at cycle 2 with rdata = 0xDEADBEEF, owner_sel = 0.
- req0 and req1 held high, mem_ready always 1 -> grant order 0,1,0,1; done pulses alternate every 2 cycles; gnt never high for both ports.
- req1 write addr1 = 0x40, wdata1 = 0x12345678, mem_ready delayed 5 cycles -> mem_* stable for 6 cycles even though addr1/wdata1 change after gnt1; done1 once; rdata = 0.
- rst_n low 2 cycles into a BUSY transaction -> mem_valid, busy, done low immediately; after release, req1 alone is granted and port 0 has priority on the next tie.
- ARB_TIMEOUT_EN, TIMEOUT = 4, mem_ready never asserted -> done0 and err0 high on the 4th BUSY cycle, rdata = 0, state IDLE. Repeat with mem_ready on that exact cycle -> done0 = 1, err0 = 0.
- mem_ready pulsed while IDLE with no requests -> no done, no state change.
